// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline package: register field width, counter width,
// hazard-controller FSM states and the load-use hazard predicate.
package pipe_hazard_ctrl_pkg;

  localparam int REG_ADDR_W  = 5;
  localparam int FLUSH_CNT_W = 16;
  localparam int WAIT_CNT_W  = 8;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_e;

  function automatic logic load_use(
    input logic                  ex_memread,
    input logic [REG_ADDR_W-1:0] ex_rt,
    input logic [REG_ADDR_W-1:0] id_rs,
    input logic [REG_ADDR_W-1:0] id_rt
  );
    return ex_memread && (ex_rt != '0) &&
           ((ex_rt == id_rs) || (ex_rt == id_rt));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-high reset;
// holds at all-ones instead of wrapping.
module sat_counter
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int WIDTH = FLUSH_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch/jump flush,
// data-memory wait with timeout and a saturating flush counter.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [REG_ADDR_W-1:0]  id_rs,
  input  logic [REG_ADDR_W-1:0]  id_rt,
  input  logic [REG_ADDR_W-1:0]  ex_rt,
  input  logic                   ex_memread,
  input  logic                   jump,
  input  logic                   bne,
  input  logic                   jr,
  input  logic                   mem_access,
  input  logic                   dmem_ready,
  output logic                   pc_write,
  output logic                   ifid_write,
  output logic                   pipe_en,
  output logic                   if_flush,
  output logic                   id_flush,
  output logic                   timeout_err,
  output logic [FLUSH_CNT_W-1:0] flush_cnt
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(TIMEOUT - 1);

  state_e                state_q;
  state_e                state_d;
  state_e                state_eff;
  logic [WAIT_CNT_W-1:0] wait_cnt_q;
  logic [WAIT_CNT_W-1:0] wait_cnt_d;
  logic                  timeout_err_q;
  logic                  timeout_err_d;
  logic                  lu;
  logic                  ms;
  logic                  issue;

  assign lu = load_use(ex_memread, ex_rt, id_rs, id_rt);
  assign ms = mem_access && !dmem_ready;

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    issue         = 1'b0;
    pc_write      = 1'b0;
    ifid_write    = 1'b0;
    pipe_en       = 1'b0;
    if_flush      = 1'b0;
    id_flush      = 1'b0;
    // A reset cycle behaves as RUN on the live inputs.
    state_eff     = reset ? RUN : state_q;

    unique case (state_eff)
      RUN: begin
        if (ms) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = '0;
        end else begin
          issue = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!dmem_ready) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
          if (wait_cnt_q == WAIT_LAST) begin
            state_d = ERR;
          end
        end else begin
          issue   = 1'b1;
          state_d = RUN;
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    if (issue) begin
      if (lu) begin
        pipe_en  = 1'b1;
        id_flush = 1'b1;
      end else begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        pipe_en    = 1'b1;
        if_flush   = jump | bne | jr;
        id_flush   = bne | jr;
      end
    end

    timeout_err_d = timeout_err_q | (state_d == ERR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;

  sat_counter #(
    .WIDTH(FLUSH_CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (if_flush),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: behavioural model compared
// every cycle, plus directed vectors with literal expectations.
module tb_pipe_hazard_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  id_rs = '0;
  logic [4:0]  id_rt = '0;
  logic [4:0]  ex_rt = '0;
  logic        ex_memread = 1'b0;
  logic        jump = 1'b0;
  logic        bne = 1'b0;
  logic        jr = 1'b0;
  logic        mem_access = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        pc_write;
  logic        ifid_write;
  logic        pipe_en;
  logic        if_flush;
  logic        id_flush;
  logic        timeout_err;
  logic [15:0] flush_cnt;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Model: 0 = running, 1 = waiting on memory, 2 = dead after timeout
  int m_mode = 0;
  int m_wait = 0;
  int m_flush = 0;
  logic [5:0] e_upd;
  logic [5:0] e_cmp;

  pipe_hazard_ctrl #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .ex_rt       (ex_rt),
    .ex_memread  (ex_memread),
    .jump        (jump),
    .bne         (bne),
    .jr          (jr),
    .mem_access  (mem_access),
    .dmem_ready  (dmem_ready),
    .pc_write    (pc_write),
    .ifid_write  (ifid_write),
    .pipe_en     (pipe_en),
    .if_flush    (if_flush),
    .id_flush    (id_flush),
    .timeout_err (timeout_err),
    .flush_cnt   (flush_cnt)
  );

  always #5 clk = ~clk;

  // {pc_write, ifid_write, pipe_en, if_flush, id_flush, timeout_err}
  function automatic logic [5:0] model_exp();
    logic [5:0] e;
    logic running;
    logic waiting;
    logic hazard;
    logic stalled;
    e = {5'b00000, m_mode == 2};
    running = reset || (m_mode == 0);
    waiting = !reset && (m_mode == 1);
    hazard = ex_memread && (ex_rt != 0) &&
             (ex_rt == id_rs || ex_rt == id_rt);
    stalled = (running && mem_access && !dmem_ready) ||
              (waiting && !dmem_ready) ||
              (!running && !waiting);
    if (stalled) return e;
    if (hazard) e[5:1] = 5'b00101;
    else e[5:1] = {3'b111, jump | bne | jr, bne | jr};
    return e;
  endfunction

  always @(posedge clk) begin
    e_upd = model_exp();
    if (reset) begin
      m_mode <= 0;
      m_wait <= 0;
      m_flush <= 0;
    end else begin
      if (e_upd[2] && m_flush < 65535) m_flush <= m_flush + 1;
      if (m_mode == 0 && mem_access && !dmem_ready) begin
        m_mode <= 1;
        m_wait <= 0;
      end else if (m_mode == 1) begin
        if (dmem_ready) m_mode <= 0;
        else if (m_wait + 1 >= TO) m_mode <= 2;
        else m_wait <= m_wait + 1;
      end
    end
  end

  task automatic check(input string name, input logic [15:0] got,
                       input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t",
               name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      e_cmp = model_exp();
      check("m_pc_write", 16'(pc_write), 16'(e_cmp[5]));
      check("m_ifid_write", 16'(ifid_write), 16'(e_cmp[4]));
      check("m_pipe_en", 16'(pipe_en), 16'(e_cmp[3]));
      check("m_if_flush", 16'(if_flush), 16'(e_cmp[2]));
      check("m_id_flush", 16'(id_flush), 16'(e_cmp[1]));
      check("m_timeout_err", 16'(timeout_err), 16'(e_cmp[0]));
      check("m_flush_cnt", flush_cnt, 16'(m_flush));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle();
    id_rs = 0; id_rt = 0; ex_rt = 0; ex_memread = 0;
    jump = 0; bne = 0; jr = 0; mem_access = 0; dmem_ready = 0;
  endtask

  initial begin
    cyc();
    chk_en = 1'b1;
    mid();
    check("rst_flush_cnt", flush_cnt, 16'h0);
    check("rst_timeout_err", 16'(timeout_err), 16'h0);
    check("rst_pc_write", 16'(pc_write), 16'h1);

    // Load-use through rs with jr pending: stall wins over redirect
    cyc(); reset = 0;
    ex_memread = 1; ex_rt = 8; id_rs = 8; jr = 1;
    mid();
    check("lu_pc_write", 16'(pc_write), 16'h0);
    check("lu_ifid_write", 16'(ifid_write), 16'h0);
    check("lu_id_flush", 16'(id_flush), 16'h1);
    check("lu_if_flush", 16'(if_flush), 16'h0);
    check("lu_pipe_en", 16'(pipe_en), 16'h1);
    cyc(); idle(); mid();
    check("lu_cnt_same", flush_cnt, 16'h0);

    // r0 never hazards: taken bne flushes both
    cyc(); ex_memread = 1; ex_rt = 0; id_rs = 0; bne = 1;
    mid();
    check("r0_pc_write", 16'(pc_write), 16'h1);
    check("r0_if_flush", 16'(if_flush), 16'h1);
    check("r0_id_flush", 16'(id_flush), 16'h1);
    cyc(); idle(); mid();
    check("r0_cnt", flush_cnt, 16'h1);

    cyc(); jump = 1; mid();
    check("jmp_id_flush", 16'(id_flush), 16'h0);
    cyc(); ex_memread = 1; ex_rt = 5; id_rt = 5; mid();
    check("lu_rt_pc_write", 16'(pc_write), 16'h0);

    // Three stalled cycles then ready with jump held
    for (int i = 0; i < 3; i++) begin
      cyc(); idle(); jump = 1; mem_access = 1; dmem_ready = 0;
      mid();
      check("ms_pc_write", 16'(pc_write), 16'h0);
      check("ms_pipe_en", 16'(pipe_en), 16'h0);
    end
    cyc(); dmem_ready = 1; mid();
    check("rdy_if_flush", 16'(if_flush), 16'h1);
    check("rdy_id_flush", 16'(id_flush), 16'h0);
    cyc(); idle(); mid();
    check("rdy_back_run", 16'(pc_write), 16'h1);
    check("rdy_cnt", flush_cnt, 16'h3);

    // TIMEOUT-1 wait cycles then ready with a load-use: no error
    for (int i = 0; i < TO; i++) begin
      cyc(); mem_access = 1; dmem_ready = 0;
    end
    cyc(); dmem_ready = 1; ex_memread = 1; ex_rt = 3; id_rs = 3;
    mid();
    check("mw_lu_pc_write", 16'(pc_write), 16'h0);
    check("mw_lu_id_flush", 16'(id_flush), 16'h1);
    cyc(); idle(); mid();
    check("edge_no_err", 16'(timeout_err), 16'h0);

    // Reset in MEM_WAIT with two wait cycles accumulated
    for (int i = 0; i < 3; i++) begin
      cyc(); mem_access = 1; dmem_ready = 0;
    end
    cyc(); reset = 1; mem_access = 0; mid();
    check("rst_mw_run_rules", 16'(pc_write), 16'h1);
    cyc(); reset = 0; idle(); mid();
    check("rst_mw_cnt", flush_cnt, 16'h0);
    check("rst_mw_pc", 16'(pc_write), 16'h1);

    // Timeout: 1 RUN cycle + TO wait cycles, then ERR
    for (int i = 0; i <= TO + 1; i++) begin
      cyc(); mem_access = 1; dmem_ready = 0; mid();
      check("to_err", 16'(timeout_err), 16'(i == TO + 1));
    end
    cyc(); mem_access = 0; dmem_ready = 1; mid();
    check("err_sticky", 16'(timeout_err), 16'h1);
    check("err_pc_write", 16'(pc_write), 16'h0);
    cyc(); idle(); jump = 1; mid();
    check("err_no_flush", 16'(if_flush), 16'h0);
    cyc(); reset = 1; mid();
    check("err_rst_pc", 16'(pc_write), 16'h1);
    check("err_rst_hold", 16'(timeout_err), 16'h1);
    cyc(); reset = 0; mid();
    check("err_cleared", 16'(timeout_err), 16'h0);
    check("err_rst_cnt", flush_cnt, 16'h0);

    // Saturation of the flush counter
    for (int i = 0; i < 70000; i++) cyc();
    mid();
    check("sat_cnt", flush_cnt, 16'hFFFF);
    cyc(); mid();
    check("sat_hold", flush_cnt, 16'hFFFF);
    check("sat_if_flush", 16'(if_flush), 16'h1);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
